// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = x - y - bin, one bit per clock, LSB first.
// Operands are accepted through start/in_ready; results load with a one-cycle done pulse and then hold.
module serial_subtractor #(
  parameter int Data_width = 4,
  parameter int Cnt_width  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [Data_width-1:0] x,
  input  logic [Data_width-1:0] y,
  input  logic                  bin,
  output logic                  in_ready,
  output logic [Data_width-1:0] diff,
  output logic                  bout,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [Cnt_width-1:0] LastBit = Cnt_width'(Data_width - 1);

  state_t                state_q, state_d;
  logic [Data_width-1:0] x_q, x_d;
  logic [Data_width-1:0] y_q, y_d;
  logic [Data_width-1:0] res_q, res_d;
  logic [Data_width-1:0] diff_q, diff_d;
  logic                  b_q, b_d;
  logic                  bout_q, bout_d;
  logic [Cnt_width-1:0]  cnt_q, cnt_d;

  // Current bit slice: operands shift right, so bit i always sits at position 0.
  logic x_bit, y_bit, d_bit, b_next, accept;

  assign x_bit  = x_q[0];
  assign y_bit  = y_q[0];
  assign d_bit  = x_bit ^ y_bit ^ b_q;
  assign b_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & b_q);

  assign in_ready = (state_q != RUN);
  assign accept   = start & in_ready;
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    diff_d  = diff_q;
    b_d     = b_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          x_d     = x;
          y_d     = y;
          b_d     = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        b_d   = b_next;
        res_d = {d_bit, res_q[Data_width-1:1]};
        cnt_d = cnt_q + Cnt_width'(1);
        if (cnt_q == LastBit) begin
          // Publish the completed word (including this final bit) on the edge entering DONE.
          diff_d  = {d_bit, res_q[Data_width-1:1]};
          bout_d  = b_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      b_q     <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      b_q     <= b_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: drivers queue hand-computed results,
// per-instance monitors pop and compare on every done pulse (4-bit and 8-bit instances).
module tb_serial_subtractor;

  typedef struct {
    logic [7:0]  d;
    logic        b;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int unsigned cyc = 0;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0;
  logic       in_ready4, bout4, done4;
  logic [3:0] diff4;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0;
  logic       in_ready8, bout8, done8;
  logic [7:0] diff8;

  exp_t q4[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_done4 = 1'b0, prev_done8 = 1'b0;

  serial_subtractor #(.Data_width(4), .Cnt_width(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .bin(bin4),
    .in_ready(in_ready4), .diff(diff4), .bout(bout4), .done(done4)
  );

  serial_subtractor #(.Data_width(8), .Cnt_width(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8), .bin(bin8),
    .in_ready(in_ready8), .diff(diff8), .bout(bout8), .done(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: sample at negedge, pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done4 === 1'b1) begin
      check("done4_not_consecutive", {31'd0, prev_done4}, 32'd0);
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done4_unexpected: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        check("diff4", {28'd0, diff4}, {24'd0, e.d});
        check("bout4", {31'd0, bout4}, {31'd0, e.b});
        check("latency4", cyc, e.cyc);
      end
    end
    prev_done4 = done4 & rst_n;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      check("done8_not_consecutive", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done8_unexpected: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("diff8", {24'd0, diff8}, {24'd0, e.d});
        check("bout8", {31'd0, bout8}, {31'd0, e.b});
        check("latency8", cyc, e.cyc);
      end
    end
    prev_done8 = done8 & rst_n;
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        input logic [3:0] ed, input logic eb, input bit keep_start);
    int n = 0;
    exp_t e;
    start4 = 1'b1; x4 = a; y4 = b; bin4 = bi;
    while (in_ready4 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("issue4_timeout", n, 0);
      start4 = 1'b0;
      return;
    end
    e.d = {4'd0, ed}; e.b = eb; e.cyc = cyc + 1 + 4;
    q4.push_back(e);
    @(negedge clk);
    if (!keep_start) start4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb);
    int n = 0;
    exp_t e;
    start8 = 1'b1; x8 = a; y8 = b; bin8 = bi;
    while (in_ready8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("issue8_timeout", n, 0);
      start8 = 1'b0;
      return;
    end
    e.d = ed; e.b = eb; e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drain(input int extra);
    int n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q4.size() + q8.size(), 0);
    repeat (extra) @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_diff", {28'd0, diff4}, 32'd0);
    check("rst_bout", {31'd0, bout4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready4}, 32'd1);

    // 9 - 3, with in_ready low throughout RUN.
    issue4(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("run_in_ready_low", {31'd0, in_ready4}, 32'd0);
      @(negedge clk);
    end
    drain(2);

    // Borrow-producing and borrow-in corner cases.
    issue4(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0);
    drain(1);
    issue4(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    drain(1);
    issue4(4'hF, 4'h0, 1'b1, 4'hE, 1'b0, 1'b0);
    drain(1);
    check("hold_idle_diff", {28'd0, diff4}, 32'hE);

    // Busy rejection: start held with other operands during RUN only.
    issue4(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    x4 = 4'd1; y4 = 4'd1;
    for (int i = 0; i < 4; i++) begin
      check("busy_in_ready_low", {31'd0, in_ready4}, 32'd0);
      @(negedge clk);
    end
    start4 = 1'b0;
    drain(8);

    // Back-to-back with start held: second accept lands in DONE.
    issue4(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b1);
    issue4(4'd2, 4'd5, 1'b0, 4'hD, 1'b1, 1'b0);
    check("b2b_diff_hold", {28'd0, diff4}, 32'd3);
    check("b2b_bout_hold", {31'd0, bout4}, 32'd0);
    drain(2);

    // Reset in the middle of an operation.
    issue4(4'd7, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q4.delete();
    check("abort_diff", {28'd0, diff4}, 32'd0);
    check("abort_bout", {31'd0, bout4}, 32'd0);
    check("abort_done", {31'd0, done4}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready4}, 32'd1);
    repeat (8) @(negedge clk);
    issue4(4'd7, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);
    drain(2);

    // 8-bit instance.
    issue8(8'd200, 8'd55, 1'b0, 8'd145, 1'b0);
    drain(1);
    issue8(8'd0, 8'd1, 1'b0, 8'hFF, 1'b1);
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
